// File: rtl/mac_row.sv
// One row of a weight-stationary systolic MAC array: col tiles, two weight/psum lanes each.
// Execute tokens ripple east one tile per clock; north psums are summed in and registered south.
module mac_row #(
    parameter int unsigned bw      = 2,
    parameter int unsigned psum_bw = 9,
    parameter int unsigned col     = 4,
    parameter int unsigned inst_bw = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [bw-1:0]              in_w0,
    input  logic [bw-1:0]              in_w1,
    input  logic [psum_bw*2*col-1:0]   in_n,
    input  logic [inst_bw-1:0]         inst_w,
    output logic [psum_bw*2*col-1:0]   out_s,
    output logic [col-1:0]             valid
);

    localparam int unsigned XW    = 2 * bw;
    localparam int unsigned LANES = 2 * col;
    localparam int unsigned PD    = (col > 1) ? col - 1 : 1;

    typedef struct packed {
        logic          v;
        logic          mode;
        logic [XW-1:0] x;
    } tok_t;

    logic [XW-1:0]      w    [LANES];
    tok_t               pipe [PD];
    tok_t               cur  [col];
    logic [psum_bw-1:0] nxt  [LANES];
    logic [XW-1:0]      x_c;
    logic               load_c;
    logic               exec_c;

    assign x_c    = {in_w1, in_w0};
    assign load_c = inst_w[0];
    assign exec_c = inst_w[1] & ~inst_w[0];

    // Activation times weight, sign-extended and added to the north psum with wraparound.
    // zx selects the mode-1 path, where the activation is an unsigned (already zero-extended) value.
    function automatic logic [psum_bw-1:0] mac(
        input logic [psum_bw-1:0] n,
        input logic [XW-1:0]      a,
        input logic               zx,
        input logic [XW-1:0]      wt
    );
        int a_i;
        int p;
        a_i = zx ? int'(a) : int'($signed(a));
        p   = a_i * int'($signed(wt));
        return psum_bw'(int'($signed(n)) + p);
    endfunction

    // Token seen by each tile this cycle: tile 0 takes the west instruction directly.
    always_comb begin
        cur[0] = '{v: exec_c, mode: inst_w[2], x: x_c};
        for (int unsigned c = 1; c < col; c++) begin
            cur[c] = pipe[c-1];
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < col; c++) begin
            logic [XW-1:0] a0;
            logic [XW-1:0] a1;
            a0 = cur[c].mode ? XW'(cur[c].x[bw-1:0])  : cur[c].x;
            a1 = cur[c].mode ? XW'(cur[c].x[XW-1:bw]) : cur[c].x;
            nxt[2*c]   = mac(in_n[2*c*psum_bw +: psum_bw],     a0, cur[c].mode, w[2*c]);
            nxt[2*c+1] = mac(in_n[(2*c+1)*psum_bw +: psum_bw], a1, cur[c].mode, w[2*c+1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                w[k] <= '0;
            end
            for (int unsigned c = 0; c < PD; c++) begin
                pipe[c] <= '0;
            end
            out_s <= '0;
            valid <= '0;
        end else begin
            // Weight shift chain: newest value enters lane 0.
            if (load_c) begin
                w[0] <= x_c;
                for (int unsigned k = 1; k < LANES; k++) begin
                    w[k] <= w[k-1];
                end
            end
            for (int unsigned c = 1; c < col; c++) begin
                pipe[c-1] <= cur[c-1];
            end
            for (int unsigned c = 0; c < col; c++) begin
                valid[c] <= cur[c].v;
                if (cur[c].v) begin
                    out_s[2*c*psum_bw +: psum_bw]     <= nxt[2*c];
                    out_s[(2*c+1)*psum_bw +: psum_bw] <= nxt[2*c+1];
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_row.sv
// Directed bench for mac_row: reset, weight load, ripple timing, streaming, wrap, mode 1,
// load-priority and mid-flight reset, all against hand-computed values.
module tb_mac_row;

    localparam int BW  = 2;
    localparam int PB  = 9;
    localparam int COL = 4;
    localparam int IB  = 3;
    localparam int L   = 2 * COL;

    logic                clk = 1'b0;
    logic                reset;
    logic [BW-1:0]       in_w0;
    logic [BW-1:0]       in_w1;
    logic [PB*L-1:0]     in_n;
    logic [IB-1:0]       inst_w;
    logic [PB*L-1:0]     out_s;
    logic [COL-1:0]      valid;

    int total = 0;
    int bad   = 0;

    int ld [8] = '{1, 2, 3, -8, -8, 0, -7, 7};
    int e1 [8] = '{14, -14, 0, -16, -16, 6, 4, 2};

    mac_row #(.bw(BW), .psum_bw(PB), .col(COL), .inst_bw(IB)) dut (
        .clk    (clk),
        .reset  (reset),
        .in_w0  (in_w0),
        .in_w1  (in_w1),
        .in_n   (in_n),
        .inst_w (inst_w),
        .out_s  (out_s),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int lane(input int j);
        logic [PB-1:0] v;
        v = out_s[j*PB +: PB];
        return int'($signed(v));
    endfunction

    function automatic int sx(input int x);
        return (x >= 8) ? x - 16 : x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_x(input int x);
        logic [3:0] v;
        v = 4'(x);
        {in_w1, in_w0} = v;
    endtask

    initial begin
        reset = 1'b1; inst_w = '0; in_w0 = '0; in_w1 = '0; in_n = '0;
        step(); step();
        reset = 1'b0;
        for (int j = 0; j < L; j++) check($sformatf("rst_lane%0d", j), lane(j), 0);
        check("rst_valid", int'(valid), 0);

        // Load 1,2,3,-8,-8,0,-7,7 -> w[0..7] = 7,-7,0,-8,-8,3,2,1
        for (int i = 0; i < 8; i++) begin
            inst_w = 3'b001; set_x(ld[i]); step();
        end
        check("load_valid", int'(valid), 0);

        // Single execute X=2, ripple across tiles
        inst_w = 3'b010; set_x(2); step();
        inst_w = 3'b000;
        for (int t = 0; t < COL; t++) begin
            check($sformatf("rip_lane%0d", 2*t),   lane(2*t),   e1[2*t]);
            check($sformatf("rip_lane%0d", 2*t+1), lane(2*t+1), e1[2*t+1]);
            check($sformatf("rip_valid%0d", t), int'(valid), 1 << t);
            if (t > 0) check("rip_hold0", lane(0), 14);
            if (t < COL - 1) step();
        end
        for (int j = 0; j < L; j++) check($sformatf("rip_final%0d", j), lane(j), e1[j]);

        // Back-to-back X=0..15
        for (int i = 0; i < 19; i++) begin
            if (i < 16) begin
                inst_w = 3'b010; set_x(i);
            end else begin
                inst_w = 3'b000;
            end
            step();
            if (i < 16) check($sformatf("str_lane0_x%0d", i), lane(0), 7 * sx(i));
            if (i >= 3) check($sformatf("str_lane7_x%0d", i - 3), lane(7), sx(i - 3));
            if (i >= 3 && i <= 15) check("str_valid", int'(valid), 15);
        end
        inst_w = 3'b000;
        step();
        check("str_idle_valid", int'(valid), 0);

        // North psum accumulate and wrap
        in_n = '0; in_n[PB-1:0] = 9'd100;
        inst_w = 3'b010; set_x(15); step();
        check("acc_93", lane(0), 93);
        in_n[PB-1:0] = 9'd255; set_x(7); step();
        check("wrap_m208", lane(0), -208);
        inst_w = 3'b000; in_n = '0;
        repeat (4) step();

        // Mode 1: a0=3, a1=2 unsigned
        inst_w = 3'b110; in_w0 = 2'd3; in_w1 = 2'd2; step();
        inst_w = 3'b000;
        check("m1_lane0", lane(0), 21);
        check("m1_lane1", lane(1), -14);
        check("m1_valid", int'(valid), 1);
        step();
        check("m1_lane2", lane(2), 0);
        check("m1_lane3", lane(3), -16);
        repeat (3) step();

        // Load has priority over execute: weights shift, no token
        inst_w = 3'b011; set_x(5); step();
        check("ldpri_valid0", int'(valid), 0);
        inst_w = 3'b000; step();
        check("ldpri_valid1", int'(valid), 0);
        step();
        check("ldpri_valid2", int'(valid), 0);
        // w now 5,7,-7,0,-8,-8,3,2
        inst_w = 3'b010; set_x(1); step();
        inst_w = 3'b000;
        check("shift_lane0", lane(0), 5);
        check("shift_lane1", lane(1), 7);
        step();
        check("shift_lane2", lane(2), -7);
        check("shift_lane3", lane(3), 0);
        step(); step();
        check("shift_lane6", lane(6), 3);
        check("shift_lane7", lane(7), 2);
        step();

        // Reset with tokens in flight
        inst_w = 3'b010; set_x(1); step();
        inst_w = 3'b000; reset = 1'b1; step();
        reset = 1'b0;
        for (int j = 0; j < L; j++) check($sformatf("mrst_lane%0d", j), lane(j), 0);
        check("mrst_valid", int'(valid), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mrst_late%0d", i), int'(valid), 0);
        end

        // Weights cleared by reset: result is just the north psum
        in_n = '0; in_n[PB-1:0] = 9'd5;
        inst_w = 3'b010; set_x(3); step();
        inst_w = 3'b000;
        check("wclr_lane0", lane(0), 5);
        check("wclr_valid", int'(valid), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_row.md
# mac_row

One row of a weight-stationary systolic MAC array: `col` tiles side by side, each holding two signed 4-bit weights and producing two partial sums per cycle. Weights and activations enter from the west edge (`in_w0`, `in_w1`). Activations ripple east one tile per clock. Each tile adds its products to partial sums arriving from the north (`in_n`) and drives the results south (`out_s`) to the next row or the output stage.

## Interface
Parameters (positional order bw, psum_bw, col, inst_bw):
- `bw`, 2: width of each west input half; a full operand is X = {in_w1, in_w0}, 2·bw = 4 bits.
- `psum_bw`, 9: partial-sum width, signed two's complement.
- `col`, 4: number of tiles; the row has 2·col psum lanes.
- `inst_bw`, 3: instruction width. bit0 = weight load, bit1 = execute, bit2 = mode.

Ports:
- `clk`  in  1  clock. Single clock domain, all state on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_w0`  in  bw  low half of X, or activation a0 in mode 1.
- `in_w1`  in  bw  high half of X, or activation a1 in mode 1.
- `in_n`  in  psum_bw·2·col  north psums. Lane j occupies bits [psum_bw·(j+1)-1 : psum_bw·j].
- `inst_w`  in  inst_bw  instruction, sampled at the west edge.
- `out_s`  out  psum_bw·2·col  south psums, same lane packing as `in_n`.
- `valid`  out  col  valid[c] is high for the cycle in which tile c's lanes (2c, 2c+1) are updated.

## Operation
- Tile c owns lanes 2c and 2c+1 and weight registers w[2c] and w[2c+1]. Each weight register is 4-bit signed.
- Weight load (inst_w[0]=1):
  - Global shift chain on each such cycle: w[0] <= X and w[k] <= w[k-1] for k = 1..2·col-1.
  - After 2·col consecutive loads, w[2·col-1] holds the first value loaded and w[0] holds the last.
  - Load has priority: when bit0 and bit1 are both 1, only the load happens and no execute is issued.
- Execute (inst_w[1]=1, inst_w[0]=0):
  - An execute token carrying {mode, in_w1, in_w0} enters tile 0 in the same cycle.
  - A per-tile pipeline register passes the token to tile c+1 one cycle later.
  - Mode 0: both lanes use activation A = X, 4-bit signed.
  - Mode 1: lane 2c uses a0 = in_w0 and lane 2c+1 uses a1 = in_w1. Each is a zero-extended unsigned bw-bit value.
  - When tile c holds a token: out_s[j] <= in_n[j] + sext(A_j · w[j]) for j in {2c, 2c+1}, and valid[c] <= 1.
  - `in_n` lanes are sampled at that same edge, with no internal delay.
  - The product is signed with a 4-bit weight, and the result is sign-extended to psum_bw.
  - The addition wraps modulo 2^psum_bw with no saturation.
- Idle tile (no token): out_s lanes of that tile hold their value, and valid[c] <= 0.
- inst_w = 0 is a no-op. Tokens already in flight still complete.
- Reset clears all weights, pipeline tokens, out_s (to 0) and valid (to 0). A reset mid-operation discards in-flight tokens.

## Timing
- Weight load takes effect at the sampling edge. The new weight is usable by an execute issued on the next cycle.
- Execute latency for tile c is c+1 rising edges after the cycle inst_w is presented.
- A full row result appears col edges after issue.
- Throughput is one execute per cycle. Back-to-back executes produce one result per tile per cycle.
- Loading weights while tokens are in flight is allowed. A token uses whatever w[j] holds when it reaches tile c.
- Reset has priority over load and execute in the same cycle.

## Test plan
- Reset, then inspect the outputs -> out_s = 0 and valid = 0 on every lane.
- Reset, then load X = 1,2,3,-8,-8,0,-7,7 -> w[0..7] = 7,-7,0,-8,-8,3,2,1.
  - Execute mode 0 with X = 2 and in_n = 0 for one cycle, then inst 0.
  - Edge 1: lanes 0,1 = 14,-14, valid = 0001.
  - Edge 2: lanes 2,3 = 0,-16, valid = 0010.
  - Edge 3: lanes 4,5 = -16,6, valid = 0100.
  - Edge 4: lanes 6,7 = 4,2, valid = 1000. Earlier lanes hold their values.
- Same weights; execute X = 0..15 back-to-back, with X=8..15 read as -8..-1 -> lane 0 equals 7·sext(X) delayed one edge, and lane 7 equals 1·sext(X) delayed four edges (e.g. X=8 gives -56 on lane 0 and -8 on lane 7).
- in_n lane 0 = 100, w[0] = 7, X = -1 -> lane 0 = 93. in_n lane 0 = 255, X = 7 -> lane 0 wraps to -208.
- Mode 1 with in_w0 = 3, in_w1 = 2, w[0] = 7, w[1] = -7 -> lanes 0,1 = 21,-14.
- Assert inst 011 -> weights shift and valid stays 0. Assert reset while tokens are in flight -> all outputs are 0 next edge and no late valid appears.
